// File: rtl/haar_lift_forward.sv
// rtl/haar_lift_forward.sv - forward Haar lifting stage: pixel pairs to sum / sign-magnitude difference
//
// Pairs consecutive pixels of a raster line (a = even, b = odd) and emits
//   im11 = a + b                      (zero-extended to 16 bits)
//   im21 = {sign(a-b), |a-b|[14:0]}   (sign = 1 iff b > a)
// with a one-cycle start strobe, plus line/frame position flags.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-high reset
//   clear      in   1      synchronous flush: drops pending a, zeroes counters and outputs
//   pix_in     in   PIX_W  unsigned pixel sample
//   pix_valid  in   1      pix_in valid this cycle (always accepted)
//   im11       out  16     pair sum, 0 when start = 0
//   im21       out  16     sign-magnitude difference, 0 when start = 0
//   start      out  1      one-cycle strobe: im11/im21 carry a valid pair
//   line_end   out  1      with start: pair is the last of its line
//   frame_end  out  1      with start: pair is the last of the frame
//   pair_err   out  1      sticky pair/position misalignment flag
module haar_lift_forward #(
    parameter int PIX_W     = 8,
    parameter int LINE_LEN  = 64,
    parameter int NUM_LINES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic [15:0]      im11,
    output logic [15:0]      im21,
    output logic             start,
    output logic             line_end,
    output logic             frame_end,
    output logic             pair_err
);

    localparam int PC_W = $clog2(LINE_LEN);
    localparam int LC_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } state_t;

    state_t            state_q;
    logic [PIX_W-1:0]  a_q;
    logic [PC_W-1:0]   pix_cnt_q;
    logic [LC_W-1:0]   line_cnt_q;

    logic [14:0]       a_ext;
    logic [14:0]       b_ext;
    logic [15:0]       sum_w;
    logic [15:0]       diff_w;
    logic              last_pix;
    logic              last_line;
    logic              misalign;

    always_comb begin
        a_ext = 15'(a_q);
        b_ext = 15'(pix_in);
        sum_w = {1'b0, a_ext} + {1'b0, b_ext};
        // Equal samples take the a >= b branch, so a zero difference is always positive.
        if (a_ext >= b_ext) begin
            diff_w = {1'b0, a_ext - b_ext};
        end else begin
            diff_w = {1'b1, b_ext - a_ext};
        end
        last_pix  = (pix_cnt_q == PC_W'(LINE_LEN - 1));
        last_line = (line_cnt_q == LC_W'(NUM_LINES - 1));
        // LINE_LEN is even, so the pixel counter parity must track the FSM state;
        // any difference means the pairing has slipped against the line position.
        misalign  = (pix_cnt_q[0] != (state_q == ODD));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EVEN;
            a_q        <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            im11       <= '0;
            im21       <= '0;
            start      <= 1'b0;
            line_end   <= 1'b0;
            frame_end  <= 1'b0;
            pair_err   <= 1'b0;
        end else if (clear) begin
            state_q    <= EVEN;
            a_q        <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            im11       <= '0;
            im21       <= '0;
            start      <= 1'b0;
            line_end   <= 1'b0;
            frame_end  <= 1'b0;
            pair_err   <= 1'b0;
        end else begin
            // Outputs are strobes: they fall back to zero unless a pair completes now.
            im11      <= '0;
            im21      <= '0;
            start     <= 1'b0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;

            if (pix_valid) begin
                if (misalign) begin
                    pair_err <= 1'b1;
                end

                if (last_pix) begin
                    pix_cnt_q  <= '0;
                    line_cnt_q <= last_line ? '0 : line_cnt_q + 1'b1;
                end else begin
                    pix_cnt_q  <= pix_cnt_q + 1'b1;
                end

                case (state_q)
                    EVEN: begin
                        a_q     <= pix_in;
                        state_q <= ODD;
                    end
                    ODD: begin
                        im11      <= sum_w;
                        im21      <= diff_w;
                        start     <= 1'b1;
                        line_end  <= last_pix;
                        frame_end <= last_pix & last_line;
                        state_q   <= EVEN;
                    end
                    default: state_q <= EVEN;
                endcase
            end
        end
    end

endmodule
